// File: rtl/alu_result_select_pipe_if.sv
// Handshake/data bundle for alu_result_select_pipe: upstream select inputs and downstream result.
// Carries sel_err/err_count only when OPSEL_ONEHOT_CHECK_EN is defined.
interface alu_result_select_pipe_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_OPS    = 8,
    parameter int unsigned N_FLAGS  = 3,
    parameter int unsigned ERRCNT_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N_OPS*WIDTH-1:0]   op_data;
    logic [N_OPS-1:0]         op_sel;
    logic [N_FLAGS-1:0]       flag_in;
    logic [N_FLAGS-1:0]       flag_sel;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         result;
    logic [N_FLAGS-1:0]       flags;
    logic                     zero;
`ifdef OPSEL_ONEHOT_CHECK_EN
    logic                     sel_err;
    logic [ERRCNT_W-1:0]      err_count;
`endif

    if (ERRCNT_W < 1) begin : g_errcnt_check
        $error("ERRCNT_W must be at least 1");
    end

    modport master (
`ifdef OPSEL_ONEHOT_CHECK_EN
        input  sel_err, err_count,
`endif
        output in_valid, op_data, op_sel, flag_in, flag_sel, out_ready,
        input  in_ready, out_valid, result, flags, zero
    );

    modport slave (
`ifdef OPSEL_ONEHOT_CHECK_EN
        output sel_err, err_count,
`endif
        input  in_valid, op_data, op_sel, flag_in, flag_sel, out_ready,
        output in_ready, out_valid, result, flags, zero
    );
endinterface

// File: rtl/alu_result_select_pipe.sv
// One-hot ALU result/flag selector registered into a 2-entry skid buffer (valid/ready both sides).
// Optional OPSEL_ONEHOT_CHECK_EN adds per-entry sel_err and a saturating err_count.
module alu_result_select_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_OPS    = 8,
    parameter int unsigned N_FLAGS  = 3,
    parameter int unsigned ERRCNT_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    alu_result_select_pipe_if.slave bus
);
    if (WIDTH < 1 || N_OPS < 1 || N_FLAGS < 1 || ERRCNT_W < 1) begin : g_param_check
        $error("alu_result_select_pipe: parameters must be at least 1");
    end

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    typedef struct packed {
        logic [WIDTH-1:0]   result;
        logic [N_FLAGS-1:0] flags;
        logic               zero;
`ifdef OPSEL_ONEHOT_CHECK_EN
        logic               err;
`endif
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d, skid_q, skid_d;
    entry_t sel_entry;
    logic   push, pop;

    // Multiple select bits give the OR of the selected lanes by design.
    always_comb begin
        sel_entry = '0;
        for (int k = 0; k < int'(N_OPS); k++) begin
            sel_entry.result = sel_entry.result
                             | (bus.op_data[k*WIDTH +: WIDTH] & {WIDTH{bus.op_sel[k]}});
        end
        sel_entry.flags = bus.flag_in & bus.flag_sel;
        sel_entry.zero  = (sel_entry.result == '0);
`ifdef OPSEL_ONEHOT_CHECK_EN
        sel_entry.err   = ((bus.op_sel & (bus.op_sel - N_OPS'(1))) != '0)
                        || ((bus.op_sel == '0) && (bus.flag_sel == '0));
`endif
    end

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    head_d  = sel_entry;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    state_d = StTwo;
                    skid_d  = sel_entry;
                end else if (push && pop) begin
                    head_d  = sel_entry;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d = StOne;
                    head_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // in_ready depends only on state and rst, never on out_ready.
    always_comb begin
        bus.in_ready  = (state_q != StTwo) && !rst;
        bus.out_valid = (state_q != StEmpty);
        bus.result    = head_q.result;
        bus.flags     = head_q.flags;
        bus.zero      = head_q.zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            head_q.zero <= 1'b1;
            skid_q      <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

`ifdef OPSEL_ONEHOT_CHECK_EN
    logic [ERRCNT_W-1:0] err_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (push && sel_entry.err && (err_count_q != '1)) begin
            err_count_q <= err_count_q + ERRCNT_W'(1);
        end
    end

    assign bus.sel_err   = head_q.err;
    assign bus.err_count = err_count_q;
`endif
endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Scoreboard bench for alu_result_select_pipe: directed pushes queue expected entries,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_result_select_pipe;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned N_OPS    = 8;
    localparam int unsigned N_FLAGS  = 3;
    localparam int unsigned ERRCNT_W = 2;
    localparam int unsigned DW       = N_OPS * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0]   r;
        logic [N_FLAGS-1:0] f;
        logic               z;
        logic               e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_result_select_pipe_if #(
        .WIDTH(WIDTH), .N_OPS(N_OPS), .N_FLAGS(N_FLAGS), .ERRCNT_W(ERRCNT_W)
    ) bus ();

    alu_result_select_pipe #(
        .WIDTH(WIDTH), .N_OPS(N_OPS), .N_FLAGS(N_FLAGS), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic logic [DW-1:0] lane(int k, logic [WIDTH-1:0] v);
        logic [DW-1:0] d;
        d = '0;
        d[k*WIDTH +: WIDTH] = v;
        return d;
    endfunction

    // Monitor: scoreboard compare on transfer, plus output stability while stalled.
    logic                          stall_prev = 1'b0;
    logic [WIDTH+N_FLAGS:0]        prev_out;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && stall_prev && bus.out_valid)
            chk("stall_stable", 64'({bus.result, bus.flags, bus.zero}), 64'(prev_out));
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(bus.result), 64'hDEAD_0000_0000);
            end else begin
                e = sb.pop_front();
`ifdef OPSEL_ONEHOT_CHECK_EN
                chk("sb_entry", 64'({bus.result, bus.flags, bus.zero, bus.sel_err}), 64'(e));
`else
                chk("sb_entry", 64'({bus.result, bus.flags, bus.zero}), 64'({e.r, e.f, e.z}));
`endif
            end
        end
        stall_prev = !rst && bus.out_valid && !bus.out_ready;
        prev_out   = {bus.result, bus.flags, bus.zero};
    end

    // Call at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push(input logic [DW-1:0] d, input logic [N_OPS-1:0] s,
                        input logic [N_FLAGS-1:0] fi, input logic [N_FLAGS-1:0] fs,
                        input logic [WIDTH-1:0] er, input logic [N_FLAGS-1:0] ef,
                        input logic ee, output int waits);
        bit done = 1'b0;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.op_data  = d;
        bus.op_sel   = s;
        bus.flag_in  = fi;
        bus.flag_sel = fs;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{r: er, f: ef, z: (er == '0), e: ee});
                done = 1'b1;
            end else if (++waits > 50) begin
                chk("push_timeout", 64'(waits), 64'd0);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.op_data  = '1;
        bus.op_sel   = '1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int w;
        int maxw;
        bus.in_valid  = 1'b0;
        bus.op_data   = '0;
        bus.op_sel    = '0;
        bus.flag_in   = '0;
        bus.flag_sel  = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_flags_zero", 64'({bus.flags, bus.zero}), 64'b0001);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic select, MSB present, other lanes ignored.
        push(lane(3, 32'h8000_0001) | lane(1, 32'hFFFF_FFFF) | lane(7, 32'h1234),
             8'h08, 3'b101, 3'b000, 32'h8000_0001, 3'b000, 1'b0, w);
        drain();

        // Flag gating with no lane selected.
        push(lane(0, 32'h5555) | lane(5, 32'hAAAA), 8'h00, 3'b111, 3'b010,
             32'h0, 3'b010, 1'b0, w);
        drain();
`ifdef OPSEL_ONEHOT_CHECK_EN
        chk("err_count_after_flag", 64'(bus.err_count), 64'd0);
`endif

        // Streaming: 10 back-to-back pushes, never stalled.
        maxw = 0;
        for (int i = 1; i <= 10; i++) begin
            push(lane(0, WIDTH'(i)) | lane(4, 32'hFFFF_0000), 8'h01, 3'b000, 3'b000,
                 WIDTH'(i), 3'b000, 1'b0, w);
            if (w > maxw) maxw = w;
        end
        chk("stream_no_wait", 64'(maxw), 64'd0);
        drain();

        // Backpressure: A, B fill the buffer, C is held until out_ready rises.
        bus.out_ready = 1'b0;
        push(lane(2, 32'hA), 8'h04, 3'b001, 3'b001, 32'hA, 3'b001, 1'b0, w);
        push(lane(6, 32'hB), 8'h40, 3'b100, 3'b100, 32'hB, 3'b100, 1'b0, w);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'({bus.in_ready, bus.out_valid}), 64'b01);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        push(lane(1, 32'hC), 8'h02, 3'b010, 3'b011, 32'hC, 3'b010, 1'b0, w);
        chk("bp_c_waited", 64'(w), 64'd1);
        drain();

        // Reset while full: entries discarded.
        bus.out_ready = 1'b0;
        push(lane(0, 32'h11), 8'h01, 3'b000, 3'b000, 32'h11, 3'b000, 1'b0, w);
        push(lane(0, 32'h22), 8'h01, 3'b000, 3'b000, 32'h22, 3'b000, 1'b0, w);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_state", 64'({bus.out_valid, bus.in_ready, bus.zero}), 64'b011);
        chk("mid_rst_result", 64'(bus.result), 64'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Multi-hot select: OR of lanes; flagged as an error when the check is built in.
        push(lane(0, 32'hF0) | lane(2, 32'h0F), 8'h05, 3'b000, 3'b111,
             32'hFF, 3'b000, 1'b1, w);
        drain();
`ifdef OPSEL_ONEHOT_CHECK_EN
        chk("err_count_one", 64'(bus.err_count), 64'd1);
`endif
        for (int i = 0; i < 4; i++)
            push(lane(0, 32'hF0) | lane(2, 32'h0F), 8'h05, 3'b000, 3'b111,
                 32'hFF, 3'b000, 1'b1, w);
        drain();
`ifdef OPSEL_ONEHOT_CHECK_EN
        chk("err_count_sat", 64'(bus.err_count), 64'd3);
`endif

        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_result_select_pipe.md
Name: alu_result_select_pipe

Overview:
- Parametrised successor to the MiniRISC ALU result selector.
- Selects one of N_OPS functional-unit outputs and gates N_FLAGS comparison flags using one-hot controls.
- Registers the selection into a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU can sit in a pipelined datapath.
- Sits between the ALU functional units plus control decode and the writeback/branch stage.

Parameters:
WIDTH, 32, data width of every operand lane and of result
N_OPS, 8, number of data lanes / one-hot op-select bits
N_FLAGS, 3, number of comparison flags (default order eq, neq, less)
ERRCNT_W, 8, width of the saturating select-error counter (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream has an operation this cycle
in_ready  out  1  block can accept; transfer when in_valid && in_ready
op_data  in  N_OPS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; lane 0 = add/memaddr
op_sel  in  N_OPS  one-hot lane select; bit 0 = add OR memadd control, ORed upstream
flag_in  in  N_FLAGS  raw comparator outputs
flag_sel  in  N_FLAGS  per-flag enable controls
out_valid  out  1  result/flags/zero valid
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
result  out  WIDTH  selected result, all WIDTH bits including MSB
flags  out  N_FLAGS  flag_in & flag_sel, captured with result
zero  out  1  result == 0
sel_err  out  1  only with OPSEL_ONEHOT_CHECK_EN; see Optional Feature
err_count  out  ERRCNT_W  only with OPSEL_ONEHOT_CHECK_EN

Behaviour:
- Select function (combinational, before capture):
  - sel_result[i] = OR over k of (op_sel[k] & lane_k[i]) for every i in 0..WIDTH-1. All bits are covered, including the MSB.
  - op_sel == 0 gives sel_result = 0.
  - Multiple op_sel bits set gives the bitwise OR of the selected lanes. This is defined behaviour, not X.
  - sel_flags = flag_in & flag_sel.
  - sel_zero = (sel_result == 0).
- Storage:
  - Two entries, HEAD (drives outputs) and SKID. Each entry holds {result, flags, zero}.
  - Occupancy state: EMPTY, ONE, TWO.
- Control signals:
  - in_ready = (state != TWO) && !rst, driven from state only. No combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - push = in_valid && in_ready; pop = out_valid && out_ready.
- Transitions:
  - EMPTY, push → ONE; HEAD ← sel.
  - ONE, push && !pop → TWO; SKID ← sel; HEAD holds.
  - ONE, !push && pop → EMPTY.
  - ONE, push && pop → ONE; HEAD ← sel.
  - TWO, pop → ONE; HEAD ← SKID. No push is possible in TWO.
  - TWO, !pop → TWO; HEAD and SKID hold.
- Latency and ordering:
  - Latency from accepted push to out_valid is 1 cycle when EMPTY.
  - Order is strictly FIFO.
  - Sustained throughput is 1 op/cycle while out_ready = 1.
- Output stability: while out_valid && !out_ready, result, flags and zero must not change.
- Reset (rst = 1 at a clock edge):
  - state → EMPTY; HEAD and SKID cleared to 0.
  - out_valid = 0, result = 0, flags = 0, zero = 1 (result is 0).
  - Any in-flight entries are discarded.
  - in_ready is 0 during rst and 1 on the first cycle after rst deasserts.
- Inputs are sampled only on push. op_data changing while !push has no effect.

Optional Feature:
- Macro: OPSEL_ONEHOT_CHECK_EN.
- Defined:
  - On every push, error = (op_sel has more than one bit set) OR (op_sel == 0 while no flag_sel bit is set).
  - sel_err is stored per entry and presented with result; it follows the same FIFO timing.
  - err_count increments on each erroneous push and saturates at 2^ERRCNT_W-1.
  - rst clears err_count to 0 and sel_err to 0.
  - Data path behaviour is unchanged (still OR of lanes).
- Undefined: sel_err and err_count ports and all their logic are absent.

Test Plan:
- Basic select: WIDTH=32; lane3=0x8000_0001, op_sel=0x08, out_ready=1, one push → next cycle out_valid=1, result=0x8000_0001 (MSB present), zero=0.
- Flag gating: flag_in=3'b111, flag_sel=3'b010, op_sel=0 → result=0, zero=1, flags=3'b010; with the feature, sel_err=0 and err_count unchanged.
- Backpressure: out_ready=0, push values A, B → in_ready drops to 0 after the second push and C is held upstream; raise out_ready → A, B, C appear in order on consecutive cycles, result stable while stalled.
- Streaming: out_ready=1, 10 back-to-back pushes (lane0 = 1..10, op_sel=0x01) → 10 results 1..10 on consecutive cycles, in_ready stays 1.
- Reset mid-operation: fill to TWO, assert rst one cycle → out_valid=0, result=0, zero=1; first cycle after reset in_ready=1 and previous entries never appear.
- Feature (OPSEL_ONEHOT_CHECK_EN): op_sel=0x05 with lane0=0xF0, lane2=0x0F → result=0xFF, sel_err=1, err_count=1; with ERRCNT_W=2, five such pushes → err_count saturates at 3.
